// File: rtl/mux_if_pkg.sv
// Shared definitions for the mux host driver: bus widths, field positions, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// iw  [0] project clk, [1] project rst_n, [9:2] ui_in, [17:10] uio_in
// ow  [7:0] uo_out, [15:8] uio_out, [23:16] uio_oe
package mux_if_pkg;

  localparam int IW_W = 18;
  localparam int OW_W = 24;

  localparam int IW_CLK_BIT  = 0;
  localparam int IW_PRST_BIT = 1;
  localparam int IW_UI_LSB   = 2;
  localparam int IW_UIO_LSB  = 10;

  localparam int OW_UO_LSB      = 0;
  localparam int OW_UIO_OUT_LSB = 8;
  localparam int OW_UIO_OE_LSB  = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CLK_HI  = 3'd2,
    CLK_LO  = 3'd3,
    CAPTURE = 3'd4,
    RESP    = 3'd5
  } state_t;

  // Assemble the packed project input word from its fields.
  function automatic logic [IW_W-1:0] pack_iw(input logic [7:0] ui,
                                              input logic [7:0] uio,
                                              input logic       prst_n,
                                              input logic       pclk);
    logic [IW_W-1:0] w;
    w                    = '0;
    w[IW_CLK_BIT]        = pclk;
    w[IW_PRST_BIT]       = prst_n;
    w[IW_UI_LSB +: 8]    = ui;
    w[IW_UIO_LSB +: 8]   = uio;
    return w;
  endfunction

endpackage

// File: rtl/mux_pulse_gen.sv
// Phase/pulse timing for the host driver: times SETTLE and each clock half, counts pulses.
// Latency: combinational strobes from registered counters; counters update every cycle.
// Backpressure: none; follows the FSM state supplied by the parent.
//
// Ports: clk, rst_n (sync, active low); load/load_pulses arm a new command;
//        state is the parent FSM state; proj_clk drives iw[0];
//        phase_done marks the last cycle of a timed state; done marks the
//        last cycle before CAPTURE (end of settle with 0 pulses, or end of last CLK_LO).
module mux_pulse_gen
  import mux_if_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int HALF_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_pulses,
  input  state_t     state,
  output logic       proj_clk,
  output logic       phase_done,
  output logic       done
);

  localparam int PH_MAX = (SETTLE_CYCLES > HALF_CYCLES) ? SETTLE_CYCLES : HALF_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  logic [PH_W-1:0] phase_cnt;
  logic [PH_W-1:0] phase_last;
  logic [3:0]      pulse_cnt;
  logic            timed;

  // Terminal count for whichever timed state is active.
  always_comb begin
    timed      = 1'b0;
    phase_last = '0;
    case (state)
      SETTLE: begin
        timed      = 1'b1;
        phase_last = PH_W'(SETTLE_CYCLES - 1);
      end
      CLK_HI, CLK_LO: begin
        timed      = 1'b1;
        phase_last = PH_W'(HALF_CYCLES - 1);
      end
      default: begin
        timed      = 1'b0;
        phase_last = '0;
      end
    endcase
  end

  assign phase_done = timed && (phase_cnt == phase_last);
  assign proj_clk   = (state == CLK_HI);

  // pulse_cnt still holds the pre-decrement value here, so "1" means this
  // CLK_LO is the final low half.
  assign done = phase_done &&
                (((state == SETTLE) && (pulse_cnt == 4'd0)) ||
                 ((state == CLK_LO) && (pulse_cnt == 4'd1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      pulse_cnt <= '0;
    end else if (load) begin
      phase_cnt <= '0;
      pulse_cnt <= load_pulses;
    end else begin
      // Phase counter restarts at every state boundary so each timed state
      // begins counting from zero; it can never exceed phase_last.
      if (!timed || phase_done) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + PH_W'(1);
      end
      // Guarded decrement: the count saturates at zero instead of wrapping.
      if ((state == CLK_LO) && phase_done && (pulse_cnt != 4'd0)) begin
        pulse_cnt <= pulse_cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/mux_host_driver.sv
// Host-side driver for a muxed project: applies a command on iw, pulses the project clock, captures ow.
// Latency: response valid SETTLE_CYCLES + 2*pulses*HALF_CYCLES + 2 cycles after command accept.
// Backpressure: one command in flight; cmd_ready low until the response is taken; response held until rsp_ready.
//
// Ports: clk, rst_n (sync, active low); cmd_valid/cmd_ready with cmd_ui, cmd_uio,
//        cmd_prst_n, cmd_pulses; rsp_valid/rsp_ready with rsp_data (captured ow);
//        ena project enable; iw packed project inputs; ow packed project outputs; busy.
module mux_host_driver
  import mux_if_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int HALF_CYCLES   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [7:0]      cmd_ui,
  input  logic [7:0]      cmd_uio,
  input  logic            cmd_prst_n,
  input  logic [3:0]      cmd_pulses,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [OW_W-1:0] rsp_data,
  output logic            ena,
  output logic [IW_W-1:0] iw,
  input  logic [OW_W-1:0] ow,
  output logic            busy
);

  state_t state;
  state_t next_state;

  logic       accept;
  logic       proj_clk;
  logic       phase_done;
  logic       done;
  logic [7:0] ui_q;
  logic [7:0] uio_q;
  logic       prst_n_q;

  assign accept = cmd_valid && cmd_ready;

  mux_pulse_gen #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .HALF_CYCLES   (HALF_CYCLES)
  ) u_pulse_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept),
    .load_pulses (cmd_pulses),
    .state       (state),
    .proj_clk    (proj_clk),
    .phase_done  (phase_done),
    .done        (done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SETTLE;
      end
      SETTLE: begin
        if (phase_done) next_state = done ? CAPTURE : CLK_HI;
      end
      CLK_HI: begin
        if (phase_done) next_state = CLK_LO;
      end
      CLK_LO: begin
        if (phase_done) next_state = done ? CAPTURE : CLK_HI;
      end
      CAPTURE: begin
        next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs decoded from state. cmd_ready also looks at rst_n so nothing is
  // offered while reset is asserted.
  always_comb begin
    cmd_ready = rst_n && (state == IDLE);
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // Command fields are latched only at accept and drive iw until the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ui_q     <= '0;
      uio_q    <= '0;
      prst_n_q <= 1'b0;
      ena      <= 1'b0;
    end else if (accept) begin
      ui_q     <= cmd_ui;
      uio_q    <= cmd_uio;
      prst_n_q <= cmd_prst_n;
      ena      <= 1'b1;
    end
  end

  // ow is registered at the end of the single CAPTURE cycle and then frozen
  // for the whole response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data <= '0;
    end else if (state == CAPTURE) begin
      rsp_data <= ow;
    end
  end

  assign iw = pack_iw(ui_q, uio_q, prst_n_q, proj_clk);

endmodule

// File: tb/tb_mux_host_driver.sv
// Bench for mux_host_driver: two instances (default timing and SETTLE=2/HALF=3) share one
// stimulus stream. A cycle-level reference model derives every expected output from the
// command's accept cycle with plain arithmetic; directed tables and sequences cover corners.
module tb_mux_host_driver;

  localparam int SA = 1;
  localparam int HA = 1;
  localparam int SB = 2;
  localparam int HB = 3;
  localparam int NV = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_ui;
  logic [7:0]  cmd_uio;
  logic        cmd_prst_n;
  logic [3:0]  cmd_pulses;
  logic        rsp_ready;
  logic [23:0] ow;

  logic        cmd_ready_v [2];
  logic        rsp_valid_v [2];
  logic [23:0] rsp_data_v  [2];
  logic        ena_v       [2];
  logic [17:0] iw_v        [2];
  logic        busy_v      [2];

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  always #5 clk = ~clk;

  mux_host_driver u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready_v[0]),
    .cmd_ui     (cmd_ui),
    .cmd_uio    (cmd_uio),
    .cmd_prst_n (cmd_prst_n),
    .cmd_pulses (cmd_pulses),
    .rsp_valid  (rsp_valid_v[0]),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data_v[0]),
    .ena        (ena_v[0]),
    .iw         (iw_v[0]),
    .ow         (ow),
    .busy       (busy_v[0])
  );

  mux_host_driver #(
    .SETTLE_CYCLES (SB),
    .HALF_CYCLES   (HB)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready_v[1]),
    .cmd_ui     (cmd_ui),
    .cmd_uio    (cmd_uio),
    .cmd_prst_n (cmd_prst_n),
    .cmd_pulses (cmd_pulses),
    .rsp_valid  (rsp_valid_v[1]),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data_v[1]),
    .ena        (ena_v[1]),
    .iw         (iw_v[1]),
    .ow         (ow),
    .busy       (busy_v[1])
  );

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic chk_w(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A command accepted in cycle T occupies: settle T+1..T+S, clock pulses
  // T+S+1..T+S+2nH (high for the first H of every 2H), capture at T+S+2nH+1,
  // response from T+S+2nH+2 until taken.
  bit          m_act  [2];
  int          m_tacc [2];
  int          m_n    [2];
  logic [16:0] m_hi   [2];
  logic        m_ena  [2];
  logic [23:0] m_rsp  [2];
  bit          synced = 1'b0;

  task automatic model_step(input int i);
    int   s;
    int   h;
    int   k;
    int   cap_k;
    int   off;
    logic e_clk;
    logic e_valid;
    s       = (i == 0) ? SA : SB;
    h       = (i == 0) ? HA : HB;
    k       = 0;
    cap_k   = 0;
    e_clk   = 1'b0;
    e_valid = 1'b0;
    if (m_act[i]) begin
      k     = ncyc - m_tacc[i];
      cap_k = s + 2 * m_n[i] * h + 1;
      if (k > s && k < cap_k) begin
        off   = k - s - 1;
        e_clk = ((off % (2 * h)) < h);
      end
      e_valid = (k > cap_k);
    end
    if (synced) begin
      chk_b($sformatf("m_cmd_ready[%0d]", i), cmd_ready_v[i], rst_n && !m_act[i]);
      chk_b($sformatf("m_busy[%0d]", i), busy_v[i], m_act[i]);
      chk_b($sformatf("m_rsp_valid[%0d]", i), rsp_valid_v[i], e_valid);
      chk_w($sformatf("m_iw[%0d]", i), 24'(iw_v[i]), 24'({m_hi[i], e_clk}));
      chk_b($sformatf("m_ena[%0d]", i), ena_v[i], m_ena[i]);
      chk_w($sformatf("m_rsp_data[%0d]", i), rsp_data_v[i], m_rsp[i]);
    end
    if (!rst_n) begin
      m_act[i] = 1'b0;
      m_hi[i]  = '0;
      m_ena[i] = 1'b0;
      m_rsp[i] = '0;
    end else if (!m_act[i]) begin
      if (cmd_valid) begin
        m_act[i]  = 1'b1;
        m_tacc[i] = ncyc;
        m_n[i]    = int'(cmd_pulses);
        m_hi[i]   = {cmd_uio, cmd_ui, cmd_prst_n};
        m_ena[i]  = 1'b1;
      end
    end else if (k == cap_k) begin
      m_rsp[i] = ow;
    end else if (e_valid && rsp_ready) begin
      m_act[i] = 1'b0;
    end
  endtask

  // Inputs change 2 time units after the rising edge; the model samples on the falling edge.
  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < 2; i++) model_step(i);
    if (!rst_n) synced = 1'b1;
  end

  // ---------------- directed + random stimulus ----------------
  typedef struct {
    logic [7:0]  ui;
    logic [7:0]  uio;
    logic        prst;
    logic [3:0]  pulses;
    logic [23:0] ow_v;
    logic [17:0] exp_iw;
    int          lat_a;
    int          lat_b;
  } vec_t;

  vec_t vt [NV];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int j;
    j = 0;
    while (!(cmd_ready_v[0] && cmd_ready_v[1]) && j < 400) begin
      tick();
      j++;
    end
    chk_b("wait_idle", cmd_ready_v[0] && cmd_ready_v[1], 1'b1);
  endtask

  task automatic issue(input logic [7:0] ui, input logic [7:0] uio, input logic prst,
                       input logic [3:0] pulses);
    cmd_ui     = ui;
    cmd_uio    = uio;
    cmd_prst_n = prst;
    cmd_pulses = pulses;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin : main
    int   got   [2];
    int   rises [2];
    int   run_hi[2];
    int   run_lo[2];
    int   bad   [2];
    logic prev  [2];
    int   hlen;
    int   j;
    logic [23:0] snap [2];

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ui = '0; cmd_uio = '0;
    cmd_prst_n = 1'b0; cmd_pulses = '0; rsp_ready = 1'b0; ow = '0;

    // Latency = S + 2*n*H + 2 counted from the accept cycle.
    vt[0] = '{8'hA5, 8'h3C, 1'b1, 4'd0,  24'h123456, 18'h0F296, 3,  4};
    vt[1] = '{8'h5A, 8'hC3, 1'b0, 4'd3,  24'hABCDEF, 18'h30D68, 9,  22};
    vt[2] = '{8'hFF, 8'hFF, 1'b1, 4'd15, 24'h00FF00, 18'h3FFFE, 33, 94};
    vt[3] = '{8'h00, 8'h00, 1'b0, 4'd1,  24'hFFFFFF, 18'h00000, 5,  10};
    vt[4] = '{8'h81, 8'h7E, 1'b1, 4'd7,  24'h5A5A5A, 18'h1FA06, 17, 46};

    // Reset state.
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      chk_w($sformatf("rst_iw[%0d]", i), 24'(iw_v[i]), 24'h0);
      chk_b($sformatf("rst_ena[%0d]", i), ena_v[i], 1'b0);
      chk_b($sformatf("rst_rsp_valid[%0d]", i), rsp_valid_v[i], 1'b0);
      chk_w($sformatf("rst_rsp_data[%0d]", i), rsp_data_v[i], 24'h0);
      chk_b($sformatf("rst_cmd_ready[%0d]", i), cmd_ready_v[i], 1'b0);
      chk_b($sformatf("rst_busy[%0d]", i), busy_v[i], 1'b0);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++)
      chk_b($sformatf("rel_cmd_ready[%0d]", i), cmd_ready_v[i], 1'b1);

    // Table-driven commands: iw contents, latency, pulse shape, captured data.
    for (int v = 0; v < NV; v++) begin
      wait_idle();
      rsp_ready = 1'b1;
      ow        = vt[v].ow_v;
      issue(vt[v].ui, vt[v].uio, vt[v].prst, vt[v].pulses);
      cmd_ui     = 8'($urandom);
      cmd_uio    = 8'($urandom);
      cmd_pulses = 4'($urandom);
      for (int i = 0; i < 2; i++) begin
        got[i] = -1; rises[i] = 0; run_hi[i] = 0; run_lo[i] = 0; bad[i] = 0; prev[i] = 1'b0;
      end
      for (int jj = 1; jj <= 150 && (got[0] < 0 || got[1] < 0); jj++) begin
        if (jj == 1) begin
          for (int i = 0; i < 2; i++)
            chk_w($sformatf("vec%0d_iw[%0d]", v, i), 24'(iw_v[i]), 24'(vt[v].exp_iw));
        end
        for (int i = 0; i < 2; i++) begin
          hlen = (i == 0) ? HA : HB;
          if (got[i] < 0) begin
            if (iw_v[i][0] && !prev[i]) begin
              if (rises[i] > 0 && run_lo[i] != hlen) bad[i]++;
              rises[i]++;
              run_hi[i] = 1;
            end else if (iw_v[i][0]) begin
              run_hi[i]++;
            end else if (prev[i]) begin
              if (run_hi[i] != hlen) bad[i]++;
              run_lo[i] = 1;
            end else begin
              run_lo[i]++;
            end
            prev[i] = iw_v[i][0];
            if (rsp_valid_v[i]) begin
              got[i] = jj;
              chk_w($sformatf("vec%0d_rsp_data[%0d]", v, i), rsp_data_v[i], vt[v].ow_v);
            end
          end
        end
        tick();
      end
      chk_i($sformatf("vec%0d_latency[0]", v), got[0], vt[v].lat_a);
      chk_i($sformatf("vec%0d_latency[1]", v), got[1], vt[v].lat_b);
      for (int i = 0; i < 2; i++) begin
        chk_i($sformatf("vec%0d_rises[%0d]", v, i), rises[i], int'(vt[v].pulses));
        chk_i($sformatf("vec%0d_pulse_shape[%0d]", v, i), bad[i], 0);
      end
    end

    // Response held under backpressure, then back-to-back command.
    wait_idle();
    rsp_ready = 1'b0;
    ow        = 24'h0BEEF0;
    issue(8'h11, 8'h22, 1'b1, 4'd1);
    j = 0;
    while (!(rsp_valid_v[0] && rsp_valid_v[1]) && j < 100) begin
      tick();
      j++;
    end
    chk_b("hold_both_valid", rsp_valid_v[0] && rsp_valid_v[1], 1'b1);
    ow = 24'h123123;
    for (int i = 0; i < 2; i++) snap[i] = rsp_data_v[i];
    repeat (10) begin
      for (int i = 0; i < 2; i++) begin
        chk_b($sformatf("hold_valid[%0d]", i), rsp_valid_v[i], 1'b1);
        chk_w($sformatf("hold_data[%0d]", i), rsp_data_v[i], 24'h0BEEF0);
        chk_w($sformatf("hold_stable[%0d]", i), rsp_data_v[i], snap[i]);
        chk_b($sformatf("hold_cmd_ready[%0d]", i), cmd_ready_v[i], 1'b0);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      chk_b($sformatf("release_cmd_ready[%0d]", i), cmd_ready_v[i], 1'b1);
    issue(8'h77, 8'h88, 1'b1, 4'd0);
    for (int i = 0; i < 2; i++) begin
      chk_w($sformatf("b2b_iw[%0d]", i), 24'(iw_v[i]), 24'h0221DE);
      chk_b($sformatf("b2b_busy[%0d]", i), busy_v[i], 1'b1);
    end
    rsp_ready = 1'b1;

    // Commands offered while busy are ignored.
    wait_idle();
    issue(8'h3C, 8'hC3, 1'b1, 4'd5);
    repeat (8) begin
      cmd_ui = 8'hE7; cmd_uio = 8'h18; cmd_prst_n = 1'b0; cmd_pulses = 4'd2;
      cmd_valid = 1'b1;
      for (int i = 0; i < 2; i++)
        chk_w($sformatf("busy_ignore_iw[%0d]", i), 24'(iw_v[i] & 18'h3FFFE), 24'h030CF2);
      tick();
    end
    cmd_valid = 1'b0;

    // Reset while the project clock is high aborts the command.
    wait_idle();
    issue(8'h99, 8'h66, 1'b1, 4'd3);
    j = 0;
    while (!iw_v[0][0] && j < 20) begin
      tick();
      j++;
    end
    chk_b("abort_in_clk_hi", iw_v[0][0], 1'b1);
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk_w($sformatf("abort_iw[%0d]", i), 24'(iw_v[i]), 24'h0);
      chk_b($sformatf("abort_ena[%0d]", i), ena_v[i], 1'b0);
      chk_b($sformatf("abort_rsp_valid[%0d]", i), rsp_valid_v[i], 1'b0);
      chk_b($sformatf("abort_cmd_ready[%0d]", i), cmd_ready_v[i], 1'b0);
    end
    rst_n = 1'b1;
    repeat (120) begin
      for (int i = 0; i < 2; i++)
        chk_b($sformatf("abort_no_rsp[%0d]", i), rsp_valid_v[i], 1'b0);
      tick();
    end

    // Random traffic with occasional resets, checked by the model.
    for (int c = 0; c < 2500; c++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_ui     = 8'($urandom);
      cmd_uio    = 8'($urandom);
      cmd_prst_n = 1'($urandom);
      cmd_pulses = 4'($urandom);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      ow         = 24'($urandom);
      rst_n      = ($urandom_range(0, 299) != 0);
      tick();
    end
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at cycle %0d, required to end well before", ncyc);
    $fatal(1, "watchdog expired");
  end

endmodule
